// File: rtl/iter_div.sv
`default_nettype none
// ============================================================================
// iter_div : iterative restoring divider (signed/unsigned), one bit per cycle
// Rev 1.0
// ============================================================================
module iter_div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               div_zero_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     quot_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     dvsr_q;
  logic                 neg_quot_q;
  logic                 neg_rem_q;
  logic                 dz_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;
  logic                 div_zero_q;

  logic [WIDTH:0]       part_d;
  logic [WIDTH:0]       diff_d;
  logic                 qbit_d;
  logic [WIDTH-1:0]     quot_d;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     abs1_d;
  logic [WIDTH-1:0]     abs2_d;

  // quot_q doubles as the dividend shift register: its MSB feeds the partial
  // remainder while quotient bits enter at the LSB.
  always_comb begin
    part_d = {rem_q, quot_q[WIDTH-1]};
    diff_d = part_d - {1'b0, dvsr_q};
    qbit_d = (part_d >= {1'b0, dvsr_q});
    quot_d = {quot_q[WIDTH-2:0], qbit_d};
    rem_d  = qbit_d ? diff_d[WIDTH-1:0] : part_d[WIDTH-1:0];
    abs1_d = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    abs2_d = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q    <= 1'b0;
          div_zero_q <= 1'b0;
          result_q   <= '0;
          if (start_i && !annul_i) begin
            cnt_q      <= '0;
            quot_q     <= abs1_d;
            rem_q      <= '0;
            dvsr_q     <= abs2_d;
            dz_q       <= 1'b0;
            neg_quot_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_q  <= signed_div_i & opdata1_i[WIDTH-1];
            state_q    <= (opdata2_i == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          if (annul_i) begin
            state_q <= S_IDLE;
          end else begin
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b1;
            state_q <= S_END;
          end
        end
        S_ON: begin
          if (annul_i) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (cnt_q == LAST) begin
            // Sign correction folds into the final iteration's write-back.
            quot_q  <= neg_quot_q ? -quot_d : quot_d;
            rem_q   <= neg_rem_q ? -rem_d : rem_d;
            cnt_q   <= '0;
            state_q <= S_END;
          end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        S_END: begin
          if (start_i) begin
            result_q   <= {rem_q, quot_q};
            ready_q    <= 1'b1;
            div_zero_q <= dz_q;
          end else begin
            result_q   <= '0;
            ready_q    <= 1'b0;
            div_zero_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign div_zero_o = div_zero_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 Parameter WIDTH, default 32, operand/quotient/remainder width; legal range 8..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 signed_div_i  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-005 opdata1_i  input  WIDTH  dividend.
REQ-006 opdata2_i  input  WIDTH  divisor.
REQ-007 start_i  input  1  request; level-held by requester until ready_o seen.
REQ-008 annul_i  input  1  abort in-flight operation.
REQ-009 result_o  output  2*WIDTH  {remainder, quotient}; remainder in upper half.
REQ-010 ready_o  output  1  result_o valid.
REQ-011 div_zero_o  output  1  current result came from a zero divisor.
REQ-012 busy_o  output  1  state != IDLE.

Function
REQ-013 FSM states SHALL be IDLE, BYZERO, ON, END; registered state, registered outputs except busy_o.
REQ-014 IDLE: start_i=1 and annul_i=0 -> opdata2_i==0 goes BYZERO, else ON; operands latched on that edge; otherwise stay.
REQ-015 On entry to ON with signed_div_i=1, each negative operand SHALL be replaced by its two's-complement magnitude; sign flags latched.
REQ-016 ON SHALL perform restoring division, one quotient bit per cycle, MSB first, using a WIDTH+1-bit partial remainder; iteration counter counts 0..WIDTH-1.
REQ-017 After the WIDTH-th iteration ON SHALL go END; ready_o first high WIDTH+1 cycles after the accepting edge.
REQ-018 Signed correction: quotient negated if dividend and divisor signs differ; remainder negated if dividend negative; applied on the ON->END edge.
REQ-019 Overflow: signed min / -1 SHALL yield quotient = min (wrap), remainder 0, no flag.
REQ-020 BYZERO SHALL last exactly one cycle, then END with result_o = 0 and div_zero_o = 1; ready_o high 2 cycles after accepting edge.
REQ-021 END: ready_o=1, result_o stable; stays END while start_i=1; start_i=0 -> IDLE with ready_o=0, div_zero_o=0, result_o=0 next cycle.
REQ-022 annul_i=1 in BYZERO or ON SHALL force IDLE next cycle; ready_o stays 0; partial results discarded.
REQ-023 annul_i in END SHALL be ignored; annul_i and start_i both 1 in IDLE -> no start.
REQ-024 Operand changes after acceptance SHALL NOT affect the running operation.
REQ-025 No new operation SHALL be accepted until IDLE is re-entered (back-to-back needs one IDLE cycle).

Reset
REQ-026 rst=0 at a clock edge SHALL force IDLE, counter 0, result_o=0, ready_o=0, div_zero_o=0, sign flags 0, in any state including mid-ON.
REQ-027 Reset SHALL take priority over start_i and annul_i; no output changes between edges due to rst.
REQ-028 First start SHALL be accepted on the first edge with rst=1.

Verification (WIDTH=32)
REQ-029 Unsigned 7/2, start held -> ready_o high 33 cycles after accept, result_o=0x00000001_00000003, div_zero_o=0.
REQ-030 Signed -7 (0xFFFFFFF9) / 2 -> result_o=0xFFFFFFFF_FFFFFFFD; signed 7 / -2 -> 0x00000001_FFFFFFFD.
REQ-031 Divisor 0, dividend 0x12345678 -> ready_o 2 cycles after accept, result_o=0, div_zero_o=1; drop start_i -> outputs 0 next cycle.
REQ-032 Signed 0x80000000 / 0xFFFFFFFF -> result_o=0x00000000_80000000; unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
REQ-033 annul_i pulse at iteration 10 -> IDLE next cycle, ready_o never asserted; new 100/7 then yields 0x00000002_0000000E.
REQ-034 rst=0 mid-ON at iteration 20 -> all outputs 0, busy_o=0 next cycle; subsequent 9/3 yields 0x00000000_00000003.
